core_ifu_pcgen: RTL and testbench

CORE_IFU_PCGEN -- requirements
Module: core_ifu_pcgen

---
 rtl/core_ifu_pcgen.sv | 111 +++++++++++
 tb/tb_core_ifu_pcgen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ifu_pcgen.sv
// Fetch PC generator: issues sequential fetch addresses, tracks in-flight requests,
// pairs returned instructions with their PC and drops responses made stale by a redirect.
module core_ifu_pcgen #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [2:0] LAST_IDX = 3'(MAX_OUTSTANDING - 1);

  logic [31:0] pc_reg, pc_next;
  logic [3:0]  outstanding_reg, outstanding_next;
  logic [3:0]  drop_cnt_reg, drop_cnt_next;
  logic [2:0]  wr_ptr_reg, wr_ptr_next;
  logic [2:0]  rd_ptr_reg, rd_ptr_next;
  logic [31:0] pcq_reg [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] entry_we;

  logic dropping;
  logic req_fire, rsp_fire;
  logic rsp_dec;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST_IDX) ? 3'd0 : p + 3'd1;
  endfunction

  assign dropping  = (drop_cnt_reg != 4'd0);
  assign req_valid = !rst && !redirect_valid && (outstanding_reg < MAX_OUT);
  assign req_addr  = pc_reg;
  // Stale responses are drained unconditionally; live ones follow decode backpressure.
  assign rsp_ready = !rst && (redirect_valid || dropping || out_ready);
  assign out_valid = !rst && !redirect_valid && !dropping && rsp_valid;
  assign out_inst  = rsp_inst;
  assign out_pc    = pcq_reg[rd_ptr_reg];

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign rsp_dec  = rsp_fire && (outstanding_reg != 4'd0);

  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_pcq_we
    assign entry_we[gi] = req_fire && (wr_ptr_reg == 3'(gi));
  end

  always_comb begin
    pc_next          = pc_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    drop_cnt_next    = drop_cnt_reg;
    outstanding_next = outstanding_reg + {3'd0, req_fire} - {3'd0, rsp_dec};
    if (redirect_valid) begin
      pc_next       = {redirect_pc[31:2], 2'b00};
      drop_cnt_next = outstanding_reg - {3'd0, rsp_dec};
      wr_ptr_next   = 3'd0;
      rd_ptr_next   = 3'd0;
    end else begin
      if (req_fire) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (rsp_fire) begin
        if (dropping)
          drop_cnt_next = drop_cnt_reg - 4'd1;
        else
          rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= 4'd0;
      drop_cnt_reg    <= 4'd0;
      wr_ptr_reg      <= 3'd0;
      rd_ptr_reg      <= 3'd0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // PC storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (entry_we[i])
        pcq_reg[i] <= pc_reg;
    end
  end

endmodule

// File: tb/tb_core_ifu_pcgen.sv
// Self-checking bench for core_ifu_pcgen: LSU model with fixed latency plus an
// expected-output scoreboard of (pc, inst) pairs.
module tb_core_ifu_pcgen;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          MAX_OUT  = 8;
  localparam int          LSU_LAT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  core_ifu_pcgen #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Fetch LSU model and scoreboard state
  logic        rsp_en;
  logic [31:0] lsu_addr [$];
  int          lsu_due  [$];
  logic [31:0] exp_pc   [$];
  logic [31:0] exp_inst [$];
  logic [31:0] m_pc;
  int          m_out;
  int          m_drop;

  // Per-scenario observation counters
  int          n_req, n_out, n_stale;
  logic        got_first;
  logic [31:0] first_out_pc;
  logic [31:0] fire_log [$];
  logic [31:0] last_req_addr;
  logic        last_req_valid;
  logic        last_out_valid;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic req_fire, rsp_fire, out_fire;
    logic exp_rv, exp_rr, exp_ov;
    if (rsp_en && lsu_addr.size() > 0 && lsu_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_inst  = inst_of(lsu_addr[0]);
    end else begin
      rsp_valid = 1'b0;
      rsp_inst  = 32'h0;
    end
    #1;
    req_fire = req_valid && req_ready;
    rsp_fire = rsp_valid && rsp_ready;
    out_fire = out_valid && out_ready;
    exp_rv = !rst && !redirect_valid && (m_out < MAX_OUT);
    exp_rr = !rst && (redirect_valid || m_drop != 0 || out_ready);
    exp_ov = !rst && !redirect_valid && (m_drop == 0) && rsp_valid;
    check("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
    check("rsp_ready", {31'd0, rsp_ready}, {31'd0, exp_rr});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (req_valid && !rst) check("req_addr", req_addr, m_pc);
    if (out_valid) begin
      if (exp_pc.size() == 0) check("out_spurious", {31'd0, out_valid}, 32'd0);
      else begin
        check("out_pc", out_pc, exp_pc[0]);
        check("out_inst", out_inst, exp_inst[0]);
      end
    end
    last_req_addr  = req_addr;
    last_req_valid = req_valid;
    last_out_valid = out_valid;
    if (rst) begin
      m_pc = RESET_PC; m_out = 0; m_drop = 0;
      exp_pc.delete(); exp_inst.delete(); lsu_addr.delete(); lsu_due.delete();
    end else begin
      if (req_fire) n_req++;
      if (rsp_fire && !out_valid) n_stale++;
      if (out_fire) begin
        n_out++;
        if (!got_first) begin
          got_first    = 1'b1;
          first_out_pc = out_pc;
        end
        $display("txn cycle=%0d pc=%h inst=%h", cyc, out_pc, out_inst);
        if (exp_pc.size() > 0) begin
          void'(exp_pc.pop_front());
          void'(exp_inst.pop_front());
        end
      end
      if (rsp_fire && lsu_addr.size() > 0) begin
        void'(lsu_addr.pop_front());
        void'(lsu_due.pop_front());
      end
      if (req_fire) begin
        fire_log.push_back(req_addr);
        lsu_addr.push_back(req_addr);
        lsu_due.push_back(cyc + LSU_LAT);
        exp_pc.push_back(m_pc);
        exp_inst.push_back(inst_of(m_pc));
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        m_pc   = {redirect_pc[31:2], 2'b00};
        m_drop = m_out - (rsp_fire ? 1 : 0);
        exp_pc.delete(); exp_inst.delete();
      end else if (m_drop != 0 && rsp_fire) begin
        m_drop--;
      end
      m_out = m_out + (req_fire ? 1 : 0) - (rsp_fire ? 1 : 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    n_req = 0; n_out = 0; n_stale = 0; got_first = 1'b0; fire_log.delete();
  endtask

  task automatic drain();
    req_ready = 1'b0; rsp_en = 1'b1; out_ready = 1'b1;
    run(12);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1; redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b0; rsp_en = 1'b0; out_ready = 1'b0;
    rsp_valid = 1'b0; rsp_inst = 32'h0;
    m_pc = RESET_PC; m_out = 0; m_drop = 0;
    clear_counts();
    run(3);

    // Reset release and steady-state streaming
    rst = 1'b0; req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    #1;
    check("first_req_valid", {31'd0, req_valid}, 32'd1);
    check("first_req_addr", req_addr, RESET_PC);
    run(10);
    clear_counts();
    run(20);
    check("stream_req_count", n_req, 20);
    check("stream_out_count", n_out, 20);

    // Outstanding limit with responses withheld
    drain();
    clear_counts();
    rsp_en = 1'b0; req_ready = 1'b1;
    run(20);
    check("limit_req_count", n_req, MAX_OUT);
    rsp_en = 1'b1;
    step();
    rsp_en = 1'b0;
    clear_counts();
    run(5);
    check("limit_after_rsp", n_req, 1);

    // Redirect with three requests in flight
    drain();
    rsp_en = 1'b0; req_ready = 1'b1;
    run(3);
    clear_counts();
    redirect(32'h0000_1002);
    rsp_en = 1'b1;
    run(15);
    check("redir_stale_pops", n_stale, 3);
    check("redir_first_pc", first_out_pc, 32'h0000_1000);

    // Redirect coinciding with a response, two outstanding
    drain();
    rsp_en = 1'b0; req_ready = 1'b1;
    run(2);
    req_ready = 1'b0;
    run(3);
    clear_counts();
    rsp_en = 1'b1;
    redirect(32'h0000_2000);
    run(10);
    check("drop_stale_pops", n_stale, 2);
    check("drop_out_count", n_out, 0);

    // Decode backpressure
    req_ready = 1'b1; rsp_en = 1'b1; out_ready = 1'b1;
    run(8);
    clear_counts();
    out_ready = 1'b0;
    run(5);
    check("stall_out_count", n_out, 0);
    out_ready = 1'b1;
    run(15);

    // PC wrap, then a reset pulse mid-stream
    drain();
    req_ready = 1'b1;
    clear_counts();
    redirect(32'hFFFF_FFFC);
    run(3);
    check("wrap_fire_count", fire_log.size(), 3);
    if (fire_log.size() >= 2) check("wrap_addr", fire_log[1], 32'h0000_0000);
    rsp_en = 1'b1;
    run(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_req_valid", {31'd0, last_req_valid}, 32'd1);
    check("rst_req_addr", last_req_addr, RESET_PC);
    check("rst_out_valid", {31'd0, last_out_valid}, 32'd0);
    run(10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
